// File: rtl/c1_bus_responder.sv
`default_nettype none
// c1_bus_responder: bus-1 slave front end. Decodes the two-cycle CPU command/address
// phase, hands the request to the cache core over valid/ready, then drives the RESPONSE phase.
// Revision: 1.0
module c1_bus_responder #(
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int DATA1_BUS_SIZE    = 16,
  parameter int CTR1_BUS_SIZE     = 3,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int CACHE_ADDR_SIZE   = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE
) (
  input  logic                       CLK,
  input  logic                       RESET,
  inout  wire  [ADDR1_BUS_SIZE-1:0]  A1_WIRE,
  inout  wire  [DATA1_BUS_SIZE-1:0]  D1_WIRE,
  inout  wire  [CTR1_BUS_SIZE-1:0]   C1_WIRE,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [CTR1_BUS_SIZE-1:0]   req_cmd,
  output logic [CACHE_ADDR_SIZE-1:0] req_addr,
  output logic [31:0]                req_wdata,
  input  logic                       resp_valid,
  input  logic [31:0]                resp_rdata,
  output logic                       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR2   = 3'd1;
  localparam logic [2:0] S_TURN    = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RESP1   = 3'd5;
  localparam logic [2:0] S_RESP2   = 3'd6;
  localparam logic [2:0] S_RELEASE = 3'd7;

  localparam logic [CTR1_BUS_SIZE-1:0] CMD_NOP      = 3'd0;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ8    = 3'd1;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ16   = 3'd2;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32   = 3'd3;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_INVAL    = 3'd4;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE8   = 3'd5;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE16  = 3'd6;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE32  = 3'd7;
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_RESPONSE = 3'd7;

  logic [2:0]                 state_q, state_d;
  logic [CTR1_BUS_SIZE-1:0]   cmd_q, cmd_d;
  logic [CACHE_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       cmd_start;
  logic                       c1_oe, d1_oe;
  logic [CTR1_BUS_SIZE-1:0]   c1_out;
  logic [DATA1_BUS_SIZE-1:0]  d1_out;

  // case matching is exact, so an x/z command never starts a transaction
  always_comb begin
    cmd_start = 1'b0;
    case (C1_WIRE)
      CMD_READ8, CMD_READ16, CMD_READ32, CMD_INVAL,
      CMD_WRITE8, CMD_WRITE16, CMD_WRITE32: cmd_start = 1'b1;
      default:                              cmd_start = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          cmd_d   = C1_WIRE;
          addr_d  = {A1_WIRE, {CACHE_OFFSET_SIZE{1'b0}}};
          wdata_d = {16'h0000, D1_WIRE};
          state_d = S_ADDR2;
        end
      end
      S_ADDR2: begin
        addr_d[CACHE_OFFSET_SIZE-1:0] = A1_WIRE[CACHE_OFFSET_SIZE-1:0];
        wdata_d[31:16] = (cmd_q == CMD_WRITE32) ? D1_WIRE : 16'h0000;
        if (cmd_q == CMD_WRITE8) begin
          wdata_d[15:8] = 8'h00;
        end
        state_d = S_TURN;
      end
      S_TURN:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          rdata_d = resp_rdata;
          state_d = S_RESP1;
        end
      end
      S_RESP1: state_d = (cmd_q == CMD_READ32) ? S_RESP2 : S_RELEASE;
      S_RESP2: state_d = S_RELEASE;
      // RESPONSE shares the WRITE32 code, so C1 is left unsampled for one cycle
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    c1_oe  = 1'b0;
    c1_out = CMD_NOP;
    d1_oe  = 1'b0;
    d1_out = '0;
    case (state_q)
      S_ISSUE, S_WAIT: c1_oe = 1'b1;
      S_RESP1: begin
        c1_oe  = 1'b1;
        c1_out = CMD_RESPONSE;
        if (cmd_q == CMD_READ8) begin
          d1_oe  = 1'b1;
          d1_out = {8'h00, rdata_q[7:0]};
        end else if (cmd_q == CMD_READ16 || cmd_q == CMD_READ32) begin
          d1_oe  = 1'b1;
          d1_out = rdata_q[15:0];
        end
      end
      S_RESP2: begin
        c1_oe  = 1'b1;
        c1_out = CMD_RESPONSE;
        d1_oe  = 1'b1;
        d1_out = rdata_q[31:16];
      end
      default: begin
        c1_oe = 1'b0;
        d1_oe = 1'b0;
      end
    endcase
  end

  assign C1_WIRE = c1_oe ? c1_out : {CTR1_BUS_SIZE{1'bz}};
  assign D1_WIRE = d1_oe ? d1_out : {DATA1_BUS_SIZE{1'bz}};

  assign req_valid = (state_q == S_ISSUE);
  assign req_cmd   = cmd_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_c1_bus_responder.sv
`default_nettype none
// tb_c1_bus_responder: randomized CPU/core stimulus with a queue-based scoreboard for the
// request handshake and the bus-1 RESPONSE beats of c1_bus_responder.
// Revision: 1.0
module tb_c1_bus_responder;

  typedef struct {
    int          cv;
    int          ch;
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [15:0] data;
  } beat_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  wire  [14:0] a1_w;
  wire  [15:0] d1_w;
  wire  [2:0]  c1_w;
  logic [14:0] a1_drv = '0;
  logic [15:0] d1_drv = '0;
  logic [2:0]  c1_drv = '0;
  logic        a1_en = 1'b0, d1_en = 1'b0, c1_en = 1'b0;

  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [2:0]  req_cmd;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        busy;

  int    cyc    = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;
  bit    mon_en = 1'b0;
  req_t  exp_req[$];
  beat_t exp_beat[$];

  assign a1_w = a1_en ? a1_drv : 'z;
  assign d1_w = d1_en ? d1_drv : 'z;
  assign c1_w = c1_en ? c1_drv : 'z;

  c1_bus_responder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .A1_WIRE    (a1_w),
    .D1_WIRE    (d1_w),
    .C1_WIRE    (c1_w),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic bit rel16(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  function automatic bit rel3(input logic [2:0] v);
    return (v === 3'bzzz) || (v === 3'b000);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: request payload/valid window and RESPONSE beats against the queues
  always @(negedge CLK) begin
    bit    in_win;
    beat_t b;
    if (mon_en) begin
      while (exp_beat.size() > 0 && exp_beat[0].cyc < cyc) begin
        chk("beat_missing", 1'b0, 32'(cyc), 32'(exp_beat[0].cyc));
        void'(exp_beat.pop_front());
      end
      if (!c1_en && c1_w === 3'd7) begin
        if (exp_beat.size() == 0) begin
          chk("beat_unexpected", 1'b0, 32'(c1_w), 32'd0);
        end else begin
          b = exp_beat.pop_front();
          chk("beat_cycle", cyc == b.cyc, 32'(cyc), 32'(b.cyc));
          if (b.rd) chk("beat_d1", d1_w === b.data, 32'(d1_w), 32'(b.data));
          else      chk("beat_d1_released", rel16(d1_w), 32'(d1_w), 32'd0);
        end
      end
      in_win = exp_req.size() > 0 && cyc >= exp_req[0].cv && cyc <= exp_req[0].ch;
      chk("req_valid", req_valid === in_win, 32'(req_valid), 32'(in_win));
      if (in_win) begin
        chk("req_cmd",   req_cmd   === exp_req[0].cmd,   32'(req_cmd),  32'(exp_req[0].cmd));
        chk("req_addr",  req_addr  === exp_req[0].addr,  32'(req_addr), 32'(exp_req[0].addr));
        chk("req_wdata", req_wdata === exp_req[0].wdata, req_wdata,     exp_req[0].wdata);
        if (cyc == exp_req[0].ch) void'(exp_req.pop_front());
      end
    end
  end

  // One CPU transaction plus core responses; R = ready-low cycles, W = WAIT cycles before resp_valid
  task automatic run_txn(input logic [2:0] cmd, input logic [14:0] ahi, input logic [3:0] off,
                         input logic [15:0] wlo, input logic [15:0] whi, input logic [31:0] rd,
                         input int R, input int W, input int gap, input bit rst_wait);
    int          t0, r1;
    req_t        q;
    beat_t       b;
    logic [2:0]  pat3;
    logic [15:0] pat16;
    c1_drv = cmd; a1_drv = ahi; d1_drv = wlo;
    c1_en = 1'b1; d1_en = 1'b1; a1_en = 1'b1;
    tick();
    t0 = cyc;
    q.cv = t0 + 2;
    q.ch = t0 + 2 + R;
    q.cmd = cmd;
    q.addr = {ahi, off};
    if (cmd == 3'd7)      q.wdata = {whi, wlo};
    else if (cmd == 3'd5) q.wdata = {24'h0, wlo[7:0]};
    else                  q.wdata = {16'h0, wlo};
    exp_req.push_back(q);
    r1 = t0 + R + W + 4;
    if (!rst_wait) begin
      b.cyc = r1;
      b.rd  = (cmd >= 3'd1 && cmd <= 3'd3);
      if (cmd == 3'd1)      b.data = {8'h00, rd[7:0]};
      else if (b.rd)        b.data = rd[15:0];
      else                  b.data = 16'h0;
      exp_beat.push_back(b);
      if (cmd == 3'd3) begin
        b.cyc = r1 + 1; b.rd = 1'b1; b.data = rd[31:16];
        exp_beat.push_back(b);
      end
    end
    a1_drv = {11'($urandom), off};
    d1_drv = whi;
    c1_drv = 3'($urandom_range(1, 7));
    tick();
    pat3 = 3'($urandom); pat16 = 16'($urandom);
    c1_drv = pat3; d1_drv = pat16;
    resp_valid = 1'($urandom); resp_rdata = $urandom;
    @(negedge CLK);
    chk("turn_c1_released", c1_w === pat3,  32'(c1_w), 32'(pat3));
    chk("turn_d1_released", d1_w === pat16, 32'(d1_w), 32'(pat16));
    tick();
    c1_en = 1'b0; d1_en = 1'b0; resp_valid = 1'b0;
    for (int k = 0; k <= R; k++) begin
      req_ready = (k == R);
      if (k < R) tick();
    end
    tick();
    req_ready = 1'b0;
    if (rst_wait) begin
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_busy",      busy === 1'b0,      32'(busy),      32'd0);
      chk("rst_req_valid", req_valid === 1'b0, 32'(req_valid), 32'd0);
      chk("rst_req_cmd",   req_cmd === 3'd0,   32'(req_cmd),   32'd0);
      chk("rst_req_addr",  req_addr === 19'd0, 32'(req_addr),  32'd0);
      chk("rst_req_wdata", req_wdata === 32'd0, req_wdata,     32'd0);
      chk("rst_c1_released", rel3(c1_w),       32'(c1_w),      32'd0);
      chk("rst_d1_released", rel16(d1_w),      32'(d1_w),      32'd0);
      tick();
      resp_valid = 1'b1; resp_rdata = rd;
      tick();
      resp_valid = 1'b0;
      @(negedge CLK);
      chk("late_resp_ignored", busy === 1'b0, 32'(busy), 32'd0);
    end else begin
      for (int k = 0; k <= W; k++) begin
        resp_valid = (k == W);
        resp_rdata = (k == W) ? rd : $urandom;
        if (k < W) tick();
      end
      tick();
      resp_valid = 1'b0;
      if (cmd == 3'd3) tick();
      tick();
      // CPU leaves RESPONSE (== WRITE32) on C1 during the release cycle
      c1_drv = 3'd7; d1_drv = 16'($urandom); pat16 = d1_drv;
      c1_en = 1'b1; d1_en = 1'b1;
      @(negedge CLK);
      chk("release_c1", c1_w === 3'd7,  32'(c1_w), 32'd7);
      chk("release_d1", d1_w === pat16, 32'(d1_w), 32'(pat16));
      chk("release_busy", busy === 1'b1, 32'(busy), 32'd1);
      tick();
      c1_en = 1'b0; d1_en = 1'b0;
      @(negedge CLK);
      chk("idle_busy", busy === 1'b0, 32'(busy), 32'd0);
    end
    repeat (gap) tick();
  endtask

  initial begin
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk("reset_busy",      busy === 1'b0,       32'(busy),      32'd0);
    chk("reset_req_valid", req_valid === 1'b0,  32'(req_valid), 32'd0);
    chk("reset_req_cmd",   req_cmd === 3'd0,    32'(req_cmd),   32'd0);
    chk("reset_req_addr",  req_addr === 19'd0,  32'(req_addr),  32'd0);
    chk("reset_req_wdata", req_wdata === 32'd0, req_wdata,      32'd0);
    chk("reset_c1",        rel3(c1_w),          32'(c1_w),      32'd0);
    chk("reset_d1",        rel16(d1_w),         32'(d1_w),      32'd0);
    tick();
    RESET = 1'b0;
    mon_en = 1'b1;
    tick();

    run_txn(3'd4, 15'b000000000000010, 4'h3, 16'h1111, 16'h2222, 32'hCAFE0001, 0, 0, 1, 1'b0);
    run_txn(3'd7, 15'h1ABC, 4'hF, 16'hBEEF, 16'hDEAD, 32'h0BADF00D, 0, 0, 0, 1'b0);
    run_txn(3'd3, 15'h0123, 4'h8, 16'h3333, 16'h4444, 32'h12345678, 0, 0, 0, 1'b0);
    run_txn(3'd1, 15'h7FFF, 4'h1, 16'hABCD, 16'h5555, 32'hFFFFFFA5, 5, 0, 1, 1'b0);
    run_txn(3'd3, 15'h0456, 4'h2, 16'h6666, 16'h7777, 32'h87654321, 0, 2, 0, 1'b1);
    run_txn(3'd2, 15'h0789, 4'h5, 16'h8888, 16'h9999, 32'h13579BDF, 0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_txn(3'($urandom_range(1, 7)), 15'($urandom), 4'($urandom), 16'($urandom),
              16'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'b0);
    end

    repeat (3) tick();
    chk("req_queue_drained",  exp_req.size() == 0,  32'(exp_req.size()),  32'd0);
    chk("beat_queue_drained", exp_beat.size() == 0, 32'(exp_beat.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
